// File: rtl/jt12_timer_gen.sv
// Generalised interval timer for the jt12 family: loadable up-counter, prescaler,
// one-shot/auto-reload, sticky flag/overrun and maskable active-low IRQ.
//
// state    | meaning
// ST_IDLE  | not armed; counter and prescaler frozen until a load rising edge
// ST_ARMED | armed; counts on ticks while load is high
module jt12_timer_gen #(
  parameter int CW      = 10,
  parameter int PW      = 4,
  parameter int RST_RUN = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic          zero,
  input  logic [CW-1:0] start_value,
  input  logic          load,
  input  logic          oneshot,
  input  logic [PW-1:0] presc,
  input  logic          clr_flag,
  input  logic          irq_en,
  output logic          flag,
  output logic          ovr,
  output logic          overflow,
  output logic [CW-1:0] cnt_out,
  output logic          irq_n
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [PW-1:0] pcnt, pcnt_nx;
  logic          load_l;
  logic          flag_nx, ovr_nx;
  logic          load_edge, run, tick, presc_hit, step, wrap;

  assign load_edge = load & ~load_l;
  assign run       = load & (state == ST_ARMED);
  // a load edge owns its clock: it reloads and suppresses any coincident tick
  assign tick      = cen & zero & run & ~load_edge;
  assign presc_hit = (pcnt == presc);
  assign step      = tick & presc_hit;
  assign wrap      = step & (cnt == {CW{1'b1}});

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (load_edge) state_nx = ST_ARMED;
      ST_ARMED: if (!load_edge && wrap && oneshot) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_nx  = cnt;
    pcnt_nx = pcnt;
    if (load_edge) begin
      cnt_nx  = start_value;
      pcnt_nx = '0;
    end else if (tick) begin
      pcnt_nx = presc_hit ? '0 : pcnt + PW'(1);
      if (step) cnt_nx = wrap ? start_value : cnt + CW'(1);
    end
  end

  always_comb begin
    flag_nx = flag;
    ovr_nx  = ovr;
    if (clr_flag) begin
      flag_nx = 1'b0;
      ovr_nx  = 1'b0;
    end else if (wrap) begin
      flag_nx = 1'b1;
      if (flag) ovr_nx = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= (RST_RUN != 0) ? ST_ARMED : ST_IDLE;
      cnt      <= '0;
      pcnt     <= '0;
      flag     <= 1'b0;
      ovr      <= 1'b0;
      overflow <= 1'b0;
      // resets high so a load held through reset is not taken as a fresh edge
      load_l   <= 1'b1;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      pcnt     <= pcnt_nx;
      flag     <= flag_nx;
      ovr      <= ovr_nx;
      overflow <= wrap;
      load_l   <= load;
    end
  end

  assign cnt_out = cnt;
  assign irq_n   = ~(flag & irq_en);

endmodule

// File: tb/tb_jt12_timer_gen.sv
// Directed bench for jt12_timer_gen: expected outputs are queued as each step is
// driven and popped for comparison one clock later.
module tb_jt12_timer_gen;

  localparam int CW = 10;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cen, zero, load, oneshot, clr_flag, irq_en;
  logic [CW-1:0] start_value;
  logic [PW-1:0] presc;
  logic          flag, ovr, overflow, irq_n;
  logic [CW-1:0] cnt_out;

  jt12_timer_gen #(.CW(CW), .PW(PW), .RST_RUN(0)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .zero(zero),
    .start_value(start_value), .load(load), .oneshot(oneshot),
    .presc(presc), .clr_flag(clr_flag), .irq_en(irq_en),
    .flag(flag), .ovr(ovr), .overflow(overflow),
    .cnt_out(cnt_out), .irq_n(irq_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    string           tag;
    logic [CW+3:0]   v;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic push_exp(input string tag, input int c, input bit f,
                          input bit o, input bit ov, input bit irq);
    exp_t e;
    e.tag = tag;
    e.v   = {CW'(c), f, o, ov, irq};
    exp_q.push_back(e);
  endtask

  task automatic check_pop();
    exp_t          e;
    logic [CW+3:0] obs;
    e   = exp_q.pop_front();
    obs = {cnt_out, flag, ovr, overflow, irq_n};
    n_cmp++;
    assert (obs === e.v)
    else begin
      n_bad++;
      $error("FAIL %s observed cnt=%0d f=%b o=%b ov=%b irq_n=%b expected cnt=%0d f=%b o=%b ov=%b irq_n=%b",
             e.tag, obs[CW+3:4], obs[3], obs[2], obs[1], obs[0],
             e.v[CW+3:4], e.v[3], e.v[2], e.v[1], e.v[0]);
    end
  endtask

  // one clock with the currently driven inputs, then compare
  task automatic cyc(input string tag, input int c, input bit f,
                     input bit o, input bit ov, input bit irq);
    push_exp(tag, c, f, o, ov, irq);
    @(posedge clk);
    #1;
    check_pop();
  endtask

  initial begin
    rst_n = 1'b0; cen = 1'b0; zero = 1'b0; load = 1'b0; oneshot = 1'b0;
    clr_flag = 1'b0; irq_en = 1'b0; start_value = '0; presc = '0;
    repeat (2) @(posedge clk);
    #1;
    push_exp("reset", 0, 0, 0, 0, 1);
    check_pop();
    rst_n = 1'b1;

    // auto-reload from 1020, presc 0: period 4, ovr on second overflow
    start_value = 10'd1020; cen = 1'b1; zero = 1'b1;
    cyc("idle_after_rst", 0, 0, 0, 0, 1);
    load = 1'b1;
    cyc("t1_load", 1020, 0, 0, 0, 1);
    for (int k = 1; k <= 12; k++)
      cyc($sformatf("t1_k%0d", k), 1020 + (k % 4), k >= 4, k >= 8, (k % 4) == 0, 1);

    // irq masking does not touch flag; load low holds the counter
    load = 1'b0; irq_en = 1'b1;
    cyc("t2_irq_on", 1020, 1, 1, 0, 0);
    irq_en = 1'b0;
    cyc("t2_irq_masked", 1020, 1, 1, 0, 1);
    irq_en = 1'b1;
    clr_flag = 1'b1;
    cyc("t4_clr", 1020, 0, 0, 0, 1);
    clr_flag = 1'b0;

    // start 1023 with presc 15: one overflow per 16 ticks
    start_value = 10'd1023; presc = 4'd15; load = 1'b1;
    cyc("t2p_load", 1023, 0, 0, 0, 1);
    for (int j = 1; j <= 32; j++)
      cyc($sformatf("t2p_j%0d", j), 1023, j >= 16, j >= 32,
          (j == 16) || (j == 32), !(j >= 16));
    load = 1'b0;
    cyc("t2p_hold", 1023, 1, 1, 0, 0);
    clr_flag = 1'b1;
    cyc("t2p_clr", 1023, 0, 0, 0, 1);
    clr_flag = 1'b0;

    // one-shot from 1022: overflow after 2 ticks, then frozen
    start_value = 10'd1022; presc = 4'd0; oneshot = 1'b1; load = 1'b1;
    cyc("t3_load", 1022, 0, 0, 0, 1);
    cyc("t3_k1", 1023, 0, 0, 0, 1);
    cyc("t3_k2", 1022, 1, 0, 1, 0);
    for (int k = 3; k <= 22; k++)
      cyc($sformatf("t3_frozen%0d", k), 1022, 1, 0, 0, 0);
    oneshot = 1'b0;
    cyc("t3_noauto", 1022, 1, 0, 0, 0);
    oneshot = 1'b1; load = 1'b0;
    cyc("t3_load_low", 1022, 1, 0, 0, 0);
    load = 1'b1;
    cyc("t3_reload", 1022, 1, 0, 0, 0);
    cyc("t3_r1", 1023, 1, 0, 0, 0);
    cyc("t3_r2", 1022, 1, 1, 1, 0);
    cyc("t3_r_frozen", 1022, 1, 1, 0, 0);

    // clr_flag on the overflow clock wins over the set
    load = 1'b0; oneshot = 1'b0; clr_flag = 1'b1;
    cyc("t5_pre_clr", 1022, 0, 0, 0, 1);
    clr_flag = 1'b0; load = 1'b1;
    cyc("t5_load", 1022, 0, 0, 0, 1);
    cyc("t5_k1", 1023, 0, 0, 0, 1);
    clr_flag = 1'b1;
    cyc("t5_k2_clr", 1022, 0, 0, 1, 1);
    clr_flag = 1'b0;
    cyc("t5_k3", 1023, 0, 0, 0, 1);
    cyc("t5_k4", 1022, 1, 0, 1, 0);

    // async reset mid-count at cnt=500 with load held high
    start_value = 10'd497; load = 1'b0;
    cyc("t6_load_low", 1022, 1, 0, 0, 0);
    load = 1'b1;
    cyc("t6_load", 497, 1, 0, 0, 0);
    cyc("t6_k1", 498, 1, 0, 0, 0);
    cyc("t6_k2", 499, 1, 0, 0, 0);
    cyc("t6_k3", 500, 1, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    push_exp("t6_async_rst", 0, 0, 0, 0, 1);
    check_pop();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++)
      cyc($sformatf("t6_idle%0d", k), 0, 0, 0, 0, 1);
    load = 1'b0;
    cyc("t6_load_fall", 0, 0, 0, 0, 1);
    load = 1'b1;
    cyc("t6_reload", 497, 0, 0, 0, 1);
    cyc("t6_step", 498, 0, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
